// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - multi-channel ADC scan sequencer with averaging
//
// Walks the enabled channels in ascending order, issuing each channel
// 2^AVG_LOG2 times as 6-bit ADC configuration words, one frame at a time.
// The ADC returns each sample one frame late, so the first frame of a scan
// is a priming frame and the last one is a flush frame carrying no config.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  pulse; begins a scan when idle and the mask is non-zero
//   continuous             rescan at each wrap while high
//   ch_mask, unipolar      channel enables and UNI bit, snapshotted per scan
//   frame_req, cfg_word    frame request and the config shifted during it
//   frame_ack, adc_data    frame completion strobe and returned sample
//   busy                   scan in progress
//   res_valid/res_ch/res_data  averaged per-channel result strobe
//   scan_done              pulses with the last result of each scan
module adc_scan_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  input  logic        unipolar,
  output logic        frame_req,
  output logic [5:0]  cfg_word,
  input  logic        frame_ack,
  input  logic [11:0] adc_data,
  output logic        busy,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        scan_done
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int REP_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] CH_RANGE = 8'((1 << NUM_CH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // Lowest set bit of m at or above index 'from'; bit 3 flags a hit.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // S/D=1 (single-ended), O/S=c[0], S1=c[2], S0=c[1], UNI, SLP=0.
  function automatic logic [5:0] cfg_of(input logic [2:0] c, input logic uni);
    return {1'b1, c[0], c[2], c[1], uni, 1'b0};
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic               uni_q, uni_d;
  logic [2:0]         iss_ch_q, iss_ch_d;
  logic [REP_W-1:0]   iss_rep_q, iss_rep_d;
  logic               iss_valid_q, iss_valid_d;
  logic [2:0]         pend_ch_q, pend_ch_d;
  logic [REP_W-1:0]   pend_rep_q, pend_rep_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_last_q, pend_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [5:0]         cfg_word_q, cfg_word_d;
  logic               res_valid_q, res_valid_d;
  logic [2:0]         res_ch_q, res_ch_d;
  logic [11:0]        res_data_q, res_data_d;
  logic               scan_done_q, scan_done_d;

  logic [7:0]         eff_mask;
  logic [3:0]         first_new;
  logic [3:0]         next_iss;
  logic               iss_last;
  logic [ACC_W-1:0]   acc_sum;

  assign eff_mask  = ch_mask & CH_RANGE;
  assign first_new = find_ch(eff_mask, 4'd0);
  assign next_iss  = find_ch(mask_q, {1'b0, iss_ch_q} + 4'd1);
  // The issued frame is the final one of its scan: last rep, no higher channel.
  assign iss_last  = iss_valid_q && (iss_rep_q == REP_LAST) && !next_iss[3];
  // Rep 0 restarts the sum instead of adding to the previous channel's total.
  assign acc_sum   = ((pend_rep_q == '0) ? '0 : acc_q) + ACC_W'(adc_data);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    uni_d        = uni_q;
    iss_ch_d     = iss_ch_q;
    iss_rep_d    = iss_rep_q;
    iss_valid_d  = iss_valid_q;
    pend_ch_d    = pend_ch_q;
    pend_rep_d   = pend_rep_q;
    pend_valid_d = pend_valid_q;
    pend_last_d  = pend_last_q;
    acc_d        = acc_q;
    cfg_word_d   = cfg_word_q;
    res_valid_d  = 1'b0;
    res_ch_d     = res_ch_q;
    res_data_d   = res_data_q;
    scan_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && first_new[3]) begin
          state_d      = S_RUN;
          mask_d       = eff_mask;
          uni_d        = unipolar;
          iss_ch_d     = first_new[2:0];
          iss_rep_d    = '0;
          iss_valid_d  = 1'b1;
          pend_valid_d = 1'b0;
          pend_last_d  = 1'b0;
          cfg_word_d   = cfg_of(first_new[2:0], unipolar);
        end
      end
      default: begin
        if (frame_ack) begin
          if (pend_valid_q) begin
            acc_d = acc_sum;
            if (pend_rep_q == REP_LAST) begin
              res_valid_d = 1'b1;
              res_ch_d    = pend_ch_q;
              res_data_d  = acc_sum[AVG_LOG2 +: 12];
              scan_done_d = pend_last_q;
            end
          end
          pend_ch_d    = iss_ch_q;
          pend_rep_d   = iss_rep_q;
          pend_valid_d = iss_valid_q;
          pend_last_d  = iss_last;

          if (state_q == S_FLUSH) begin
            state_d      = S_IDLE;
            pend_valid_d = 1'b0;
            iss_valid_d  = 1'b0;
          end else if (iss_rep_q != REP_LAST) begin
            iss_rep_d = iss_rep_q + REP_W'(1);
          end else if (next_iss[3]) begin
            iss_ch_d   = next_iss[2:0];
            iss_rep_d  = '0;
            cfg_word_d = cfg_of(next_iss[2:0], uni_q);
          end else if (continuous && first_new[3]) begin
            mask_d     = eff_mask;
            uni_d      = unipolar;
            iss_ch_d   = first_new[2:0];
            iss_rep_d  = '0;
            cfg_word_d = cfg_of(first_new[2:0], unipolar);
          end else begin
            // Flush frame: config left as-is, its returned data is the last sample.
            state_d     = S_FLUSH;
            iss_valid_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      uni_q        <= 1'b0;
      iss_ch_q     <= '0;
      iss_rep_q    <= '0;
      iss_valid_q  <= 1'b0;
      pend_ch_q    <= '0;
      pend_rep_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
      acc_q        <= '0;
      cfg_word_q   <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_data_q   <= '0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      uni_q        <= uni_d;
      iss_ch_q     <= iss_ch_d;
      iss_rep_q    <= iss_rep_d;
      iss_valid_q  <= iss_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_rep_q   <= pend_rep_d;
      pend_valid_q <= pend_valid_d;
      pend_last_q  <= pend_last_d;
      acc_q        <= acc_d;
      cfg_word_q   <= cfg_word_d;
      res_valid_q  <= res_valid_d;
      res_ch_q     <= res_ch_d;
      res_data_q   <= res_data_d;
      scan_done_q  <= scan_done_d;
    end
  end

  assign frame_req = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cfg_word  = cfg_word_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign scan_done = scan_done_q;

endmodule
